// File: rtl/uart_rx_if.sv
// Output handshake of the UART receiver: one recovered word plus its error
// flags, offered under valid/ready.
interface uart_rx_if;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       parity_err;
   logic       frame_err;

   modport master (output data_out, output valid, output parity_err, output frame_err,
                   input ready);
   modport slave  (input data_out, input valid, input parity_err, input frame_err,
                   output ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 5-8 data bits, optional even parity, 1 or 2 stop bits,
// single-entry output buffer with sticky overrun.
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       rx,
   input  logic [1:0] num_data,
   input  logic       parity,
   input  logic       stop_2,
   uart_rx_if.master  m_out,
   output logic       overrun,
   output logic       busy
);

   localparam int            CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] SAMPLE = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
   } state_t;

   state_t        r_state;
   logic          r_rx_meta, r_rx_s;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_num;
   logic          r_par_en, r_stop2;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_par_acc, r_ferr;
   logic          r_busy, r_overrun;

   logic [CW-1:0] w_cnt_next;
   logic          w_sample, w_last_bit, w_ferr_final;

   assign w_cnt_next   = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
   assign w_sample     = (r_cnt == SAMPLE);
   assign w_last_bit   = (r_bit_idx == ({1'b0, r_num} + 3'd4));
   assign w_ferr_final = r_ferr | ~r_rx_s;

   assign busy    = r_busy;
   assign overrun = r_overrun;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         // NOTE: synchronizer resets to the idle level so release never looks like a start bit.
         r_rx_meta        <= 1'b1;
         r_rx_s           <= 1'b1;
         r_state          <= IDLE;
         r_cnt            <= '0;
         r_num            <= '0;
         r_par_en         <= 1'b0;
         r_stop2          <= 1'b0;
         r_bit_idx        <= '0;
         r_shift          <= '0;
         r_par_acc        <= 1'b0;
         r_ferr           <= 1'b0;
         r_busy           <= 1'b0;
         r_overrun        <= 1'b0;
         m_out.data_out   <= '0;
         m_out.valid      <= 1'b0;
         m_out.parity_err <= 1'b0;
         m_out.frame_err  <= 1'b0;
      end else begin
         r_rx_meta <= rx;
         r_rx_s    <= r_rx_meta;
         r_cnt     <= w_cnt_next;

         if (m_out.valid && m_out.ready) m_out.valid <= 1'b0;

         case (r_state)
            IDLE: begin
               if (!r_rx_s) begin
                  r_num     <= num_data;
                  r_par_en  <= parity;
                  r_stop2   <= stop_2;
                  r_bit_idx <= '0;
                  r_shift   <= '0;
                  r_par_acc <= 1'b0;
                  r_ferr    <= 1'b0;
                  r_busy    <= 1'b1;
                  // A sample point at cnt 0 means the detection cycle already validated the start.
                  r_state   <= (SAMPLE == '0) ? DATA : START;
               end else begin
                  r_cnt <= '0;
               end
            end
            START: begin
               if (w_sample) begin
                  if (r_rx_s) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_sample) begin
                  r_shift[r_bit_idx] <= r_rx_s;
                  r_par_acc          <= r_par_acc ^ r_rx_s;
                  r_bit_idx          <= r_bit_idx + 3'd1;
                  if (w_last_bit) r_state <= r_par_en ? PARITY : STOP1;
               end
            end
            PARITY: begin
               if (w_sample) begin
                  r_par_acc <= r_par_acc ^ r_rx_s;
                  r_state   <= STOP1;
               end
            end
            STOP1, STOP2: begin
               if (w_sample) begin
                  r_ferr <= w_ferr_final;
                  if (r_state == STOP1 && r_stop2) begin
                     r_state <= STOP2;
                  end else begin
                     // A low stop bit parks in WAIT_HIGH so a held break is not re-read as a start.
                     r_state <= w_ferr_final ? WAIT_HIGH : IDLE;
                     r_busy  <= w_ferr_final;
                     r_cnt   <= '0;
                     if (!m_out.valid || m_out.ready) begin
                        m_out.data_out   <= r_shift;
                        m_out.parity_err <= r_par_en & r_par_acc;
                        m_out.frame_err  <= w_ferr_final;
                        m_out.valid      <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end
            end
            WAIT_HIGH: begin
               r_cnt <= '0;
               if (r_rx_s) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_uart_rx;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk;
   logic       arst;
   logic       rx1, rx4;
   logic [1:0] num_data;
   logic       parity, stop_2;
   logic       overrun1, busy1, overrun4, busy4;

   uart_rx_if if1 ();
   uart_rx_if if4 ();

   uart_rx #(.CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .arst(arst), .rx(rx1), .num_data(num_data), .parity(parity),
      .stop_2(stop_2), .m_out(if1), .overrun(overrun1), .busy(busy1)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .arst(arst), .rx(rx4), .num_data(num_data), .parity(parity),
      .stop_2(stop_2), .m_out(if4), .overrun(overrun4), .busy(busy4)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q1[$];
   exp_t q4[$];
   exp_t e1, e4;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit use4, input logic b);
      if (use4) begin
         rx4 = b;
         tick(4);
      end else begin
         rx1 = b;
         tick(1);
      end
   endtask

   task automatic send(input bit use4, input logic [7:0] d, input int nb, input bit pen,
                       input bit pinv, input int nstop, input logic stop_val);
      logic p;
      p = pinv;
      drive_bit(use4, 1'b0);
      for (int i = 0; i < nb; i++) begin
         drive_bit(use4, d[i]);
         p = p ^ d[i];
      end
      if (pen) drive_bit(use4, p);
      for (int i = 0; i < nstop; i++) drive_bit(use4, stop_val);
   endtask

   always @(negedge clk) begin
      if (!arst && if1.valid && if1.ready) begin
         if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut1_unexpected_word: got data 0x%02h, required no word", if1.data_out);
         end else begin
            e1 = q1.pop_front();
            check("dut1_data", 32'(if1.data_out), 32'(e1.data));
            check("dut1_parity_err", 32'(if1.parity_err), 32'(e1.perr));
            check("dut1_frame_err", 32'(if1.frame_err), 32'(e1.ferr));
         end
      end
   end

   always @(negedge clk) begin
      if (!arst && if4.valid && if4.ready) begin
         if (q4.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut4_unexpected_word: got data 0x%02h, required no word", if4.data_out);
         end else begin
            e4 = q4.pop_front();
            check("dut4_data", 32'(if4.data_out), 32'(e4.data));
            check("dut4_parity_err", 32'(if4.parity_err), 32'(e4.perr));
            check("dut4_frame_err", 32'(if4.frame_err), 32'(e4.ferr));
         end
      end
   end

   initial begin
      arst      = 1'b1;
      rx1       = 1'b1;
      rx4       = 1'b1;
      num_data  = 2'b11;
      parity    = 1'b0;
      stop_2    = 1'b0;
      if1.ready = 1'b1;
      if4.ready = 1'b1;
      tick(3);
      check("rst_valid", 32'(if1.valid), 0);
      check("rst_data", 32'(if1.data_out), 0);
      check("rst_busy", 32'(busy1), 0);
      check("rst_overrun", 32'(overrun1), 0);
      arst = 1'b0;
      tick(3);

      // 8N1 0xA5: valid is a one-cycle pulse at cycle 12
      q1.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
      send(1'b0, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
      tick(1);
      check("t1_valid_c11", 32'(if1.valid), 0);
      check("t1_busy_c11", 32'(busy1), 1);
      tick(1);
      check("t1_valid_c12", 32'(if1.valid), 1);
      check("t1_busy_c12", 32'(busy1), 0);
      tick(1);
      check("t1_valid_c13", 32'(if1.valid), 0);

      // 7E2, good then inverted parity, back to back
      num_data = 2'b10;
      parity   = 1'b1;
      stop_2   = 1'b1;
      q1.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
      q1.push_back('{data: 8'h5A, perr: 1'b1, ferr: 1'b0});
      send(1'b0, 8'h5A, 7, 1'b1, 1'b0, 2, 1'b1);
      send(1'b0, 8'h5A, 7, 1'b1, 1'b1, 2, 1'b1);
      tick(4);

      // 5N1 with low stop bit then break held low
      num_data = 2'b00;
      parity   = 1'b0;
      stop_2   = 1'b0;
      q1.push_back('{data: 8'h15, perr: 1'b0, ferr: 1'b1});
      send(1'b0, 8'h15, 5, 1'b0, 1'b0, 1, 1'b0);
      rx1 = 1'b0;
      tick(20);
      check("t3_busy_break", 32'(busy1), 1);
      rx1 = 1'b1;
      tick(4);
      check("t3_busy_released", 32'(busy1), 0);

      // overrun: three frames while the consumer stalls
      num_data  = 2'b11;
      check("t4_overrun_before", 32'(overrun1), 0);
      if1.ready = 1'b0;
      q1.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
      send(1'b0, 8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
      send(1'b0, 8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
      send(1'b0, 8'h33, 8, 1'b0, 1'b0, 1, 1'b1);
      tick(4);
      check("t4_valid_held", 32'(if1.valid), 1);
      check("t4_data_held", 32'(if1.data_out), 32'h11);
      check("t4_overrun", 32'(overrun1), 1);
      if1.ready = 1'b1;
      tick(1);
      check("t4_valid_drained", 32'(if1.valid), 0);
      tick(2);

      // CLKS_PER_BIT=4: clean word, glitch, mid-frame reset, clean word
      q4.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
      send(1'b1, 8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
      tick(8);
      check("t5_first_word", 32'(if4.data_out), 32'h3C);
      rx4 = 1'b0;
      tick(1);
      rx4 = 1'b1;
      tick(12);
      check("t5_glitch_busy", 32'(busy4), 0);
      check("t5_glitch_valid", 32'(if4.valid), 0);
      drive_bit(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b1);
      check("t5_busy_mid_frame", 32'(busy4), 1);
      arst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy4), 0);
      check("t5_rst_valid", 32'(if4.valid), 0);
      check("t5_rst_data", 32'(if4.data_out), 0);
      check("t5_rst_perr", 32'(if4.parity_err), 0);
      check("t5_rst_ferr", 32'(if4.frame_err), 0);
      check("t5_rst_overrun4", 32'(overrun4), 0);
      check("t5_rst_overrun1", 32'(overrun1), 0);
      rx4 = 1'b1;
      tick(2);
      arst = 1'b0;
      tick(4);
      q4.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
      send(1'b1, 8'hC3, 8, 1'b0, 1'b0, 1, 1'b1);
      tick(8);

      // full buffer drained in the same cycle as the next completion
      if1.ready = 1'b0;
      q1.push_back('{data: 8'h81, perr: 1'b0, ferr: 1'b0});
      q1.push_back('{data: 8'h7E, perr: 1'b0, ferr: 1'b0});
      fork
         begin
            send(1'b0, 8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
            send(1'b0, 8'h7E, 8, 1'b0, 1'b0, 1, 1'b1);
         end
         begin
            tick(21);
            if1.ready = 1'b1;
            tick(1);
            if1.ready = 1'b0;
            check("t6_valid_stays", 32'(if1.valid), 1);
            check("t6_new_word", 32'(if1.data_out), 32'h7E);
            check("t6_no_overrun", 32'(overrun1), 0);
         end
      join
      tick(2);
      if1.ready = 1'b1;
      tick(1);
      check("t6_valid_drained", 32'(if1.valid), 0);
      tick(2);

      check("q1_drained", 32'(q1.size()), 0);
      check("q4_drained", 32'(q4.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
